remote_update_readback: RTL and testbench

//  Read-side companion to the remote-update configuration writer. On a start pulse it

---
 rtl/remote_update_pkg.sv | 54 +++++
 rtl/remote_update_readback_hs.sv | 61 ++++++
 rtl/remote_update_readback.sv | 142 ++++++++++++++
 tb/tb_remote_update_readback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_update_pkg.sv
// Shared definitions for the remote-update read/write controllers:
// param/source codes, FSM state encoding, read-list entry type and
// the readback list itself. Macro REMOTE_UPDATE_RD_WDTIMEOUT_EN adds
// the watchdog-timeout entry to the readback list.
package remote_update_pkg;

    localparam logic [2:0] RU_P_TRIG     = 3'b000;
    localparam logic [2:0] RU_P_BOOTADDR = 3'b100;
    localparam logic [2:0] RU_P_ANF      = 3'b101;
    localparam logic [2:0] RU_P_WDEN     = 3'b011;
    localparam logic [2:0] RU_P_WDTO     = 3'b010;

    localparam logic [1:0] RU_SRC_CUR    = 2'b00;
    localparam logic [1:0] RU_SRC_PREV1  = 2'b01;

    typedef enum logic [2:0] {
        RU_IDLE,
        RU_PRE,
        RU_ISSUE,
        RU_WAIT_HI,
        RU_WAIT_LO,
        RU_CAPTURE,
        RU_FIN
    } ru_state_t;

    typedef struct packed {
        logic [2:0] param;
        logic [1:0] source;
    } ru_entry_t;

`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    localparam int RU_RD_N = 5;
`else
    localparam int RU_RD_N = 4;
`endif
    localparam int RU_IDX_W = 3;

    // Readback list: index -> core access. Destinations follow the same order.
    function automatic ru_entry_t ru_rd_entry(input logic [RU_IDX_W-1:0] idx);
        ru_entry_t e;
        case (idx)
            3'd0:    e = '{param: RU_P_TRIG,     source: RU_SRC_PREV1};
            3'd1:    e = '{param: RU_P_BOOTADDR, source: RU_SRC_CUR};
            3'd2:    e = '{param: RU_P_ANF,      source: RU_SRC_CUR};
            3'd3:    e = '{param: RU_P_WDEN,     source: RU_SRC_CUR};
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
            3'd4:    e = '{param: RU_P_WDTO,     source: RU_SRC_CUR};
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/remote_update_readback_hs.sv
// Busy handshake helper: decides the next state while the readback FSM is in
// PRE/ISSUE/WAIT_HI/WAIT_LO and owns the per-state timeout counter. The
// counter restarts on every state entry, so each wait gets a full budget.
module ru_busy_handshake
    import remote_update_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 256
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  ru_state_t state_i,
    input  logic      busy_i,
    output ru_state_t next_o,
    output logic      timeout_o,
    output logic      read_param_o
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             met;

    // Handshake transitions, timeout detection and counter next-state
    always_comb begin
        next_o  = state_i;
        waiting = 1'b0;
        met     = 1'b0;
        case (state_i)
            RU_PRE: begin
                waiting = 1'b1;
                met     = !busy_i;
                if (met) next_o = RU_ISSUE;
            end
            RU_ISSUE: next_o = RU_WAIT_HI;
            RU_WAIT_HI: begin
                waiting = 1'b1;
                met     = busy_i;
                if (met) next_o = RU_WAIT_LO;
            end
            RU_WAIT_LO: begin
                waiting = 1'b1;
                met     = !busy_i;
                if (met) next_o = RU_CAPTURE;
            end
            default: ;
        endcase
        timeout_o = waiting && !met && (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));
        if (timeout_o) next_o = RU_IDLE;
        cnt_d = (waiting && !met && !timeout_o) ? cnt_q + CNT_W'(1) : '0;
    end

    // Timeout counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign read_param_o = (state_i == RU_ISSUE);

endmodule

// File: rtl/remote_update_readback.sv
// Remote-update readback controller: on rd_start walks the readback list,
// reading each core parameter through the busy handshake and latching the
// result into a status snapshot for the host. Macro
// REMOTE_UPDATE_RD_WDTIMEOUT_EN adds the wd_timeout_o entry and output.
module remote_update_readback
    import remote_update_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_start_i,
    output logic        rd_active_o,
    output logic        rd_done_o,
    output logic        rd_error_o,
    output logic        read_param_o,
    output logic [2:0]  param_o,
    output logic [1:0]  read_source_o,
    input  logic        busy_i,
    input  logic [23:0] data_out_i,
    output logic [4:0]  trig_cond_o,
    output logic [23:0] boot_addr_o,
    output logic        anf_o,
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    output logic [11:0] wd_timeout_o,
`endif
    output logic        wd_en_o
);

    ru_state_t            state_q, state_d;
    ru_state_t            hs_next;
    logic                 hs_timeout;
    logic [RU_IDX_W-1:0]  idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 cap;
    ru_entry_t            entry;
    logic                 hold;

    logic [4:0]           trig_q;
    logic [23:0]          boot_q;
    logic                 anf_q;
    logic                 wden_q;
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    logic [11:0]          wdto_q;
`endif

    ru_busy_handshake #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_hs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .state_i      (state_q),
        .busy_i       (busy_i),
        .next_o       (hs_next),
        .timeout_o    (hs_timeout),
        .read_param_o (read_param_o)
    );

    // Sequence control: start acceptance, handshake hand-off, list stepping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cap     = 1'b0;
        case (state_q)
            RU_IDLE: begin
                if (rd_start_i) begin
                    state_d = RU_PRE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RU_PRE, RU_ISSUE, RU_WAIT_HI, RU_WAIT_LO: begin
                state_d = hs_next;
                if (hs_timeout) err_d = 1'b1;
            end
            RU_CAPTURE: begin
                cap     = 1'b1;
                idx_d   = idx_q + RU_IDX_W'(1);
                state_d = (idx_q == RU_IDX_W'(RU_RD_N - 1)) ? RU_FIN : RU_PRE;
            end
            RU_FIN:  state_d = RU_IDLE;
            default: state_d = RU_IDLE;
        endcase
    end

    // FSM, index and sticky error registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RU_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Snapshot: only CAPTURE writes, and only the current entry's destination
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q <= '0;
            boot_q <= '0;
            anf_q  <= 1'b0;
            wden_q <= 1'b0;
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
            wdto_q <= '0;
`endif
        end else if (cap) begin
            case (idx_q)
                3'd0:    trig_q <= data_out_i[4:0];
                3'd1:    boot_q <= data_out_i;
                3'd2:    anf_q  <= data_out_i[0];
                3'd3:    wden_q <= data_out_i[0];
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
                3'd4:    wdto_q <= data_out_i[11:0];
`endif
                default: ;
            endcase
        end
    end

    // Core select is held from PRE through CAPTURE, zero otherwise
    assign entry         = ru_rd_entry(idx_q);
    assign hold          = (state_q inside {RU_PRE, RU_ISSUE, RU_WAIT_HI, RU_WAIT_LO, RU_CAPTURE});
    assign param_o       = hold ? entry.param  : 3'b000;
    assign read_source_o = hold ? entry.source : 2'b00;

    assign rd_active_o   = (state_q != RU_IDLE);
    assign rd_done_o     = (state_q == RU_FIN);
    assign rd_error_o    = err_q;

    assign trig_cond_o   = trig_q;
    assign boot_addr_o   = boot_q;
    assign anf_o         = anf_q;
    assign wd_en_o       = wden_q;
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    assign wd_timeout_o  = wdto_q;
`endif

endmodule

// File: tb/tb_remote_update_readback.sv
// Self-checking bench for remote_update_readback with a behavioural core model.
module tb_remote_update_readback;

    localparam int TO = 16;
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    localparam int N = 5;
`else
    localparam int N = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_start = 1'b0;
    logic        rd_active, rd_done, rd_error, read_param;
    logic [2:0]  param;
    logic [1:0]  read_source;
    logic        busy;
    logic [23:0] data_out;
    logic [4:0]  trig_cond;
    logic [23:0] boot_addr;
    logic        anf, wd_en;
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
    logic [11:0] wd_timeout;
`endif

    always #5 clk = ~clk;

    remote_update_readback #(.BUSY_TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_start_i    (rd_start),
        .rd_active_o   (rd_active),
        .rd_done_o     (rd_done),
        .rd_error_o    (rd_error),
        .read_param_o  (read_param),
        .param_o       (param),
        .read_source_o (read_source),
        .busy_i        (busy),
        .data_out_i    (data_out),
        .trig_cond_o   (trig_cond),
        .boot_addr_o   (boot_addr),
        .anf_o         (anf),
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
        .wd_timeout_o  (wd_timeout),
`endif
        .wd_en_o       (wd_en)
    );

    int checks = 0;
    int fails  = 0;

    // Expected read list as {param, source}, in order
    logic [4:0] lst [0:4] = '{5'b000_01, 5'b100_00, 5'b101_00, 5'b011_00, 5'b010_00};

    // ---------------- core model ----------------
    logic [23:0] tbl [0:7][0:3];
    logic        force_busy = 1'b0;
    logic        core_dead  = 1'b0;
    logic        busy_q     = 1'b0;
    int          core_t     = 0;
    logic [23:0] dout       = '0;

    assign busy     = busy_q | force_busy;
    assign data_out = dout;

    // busy rises two cycles after the strobe, stays up three cycles, data valid on fall
    always @(posedge clk) begin
        if (rst) begin
            core_t <= 0;
            busy_q <= 1'b0;
        end else if (read_param && !core_dead) begin
            core_t <= 1;
            dout   <= 24'($urandom);
        end else if (core_t != 0) begin
            if (core_t == 4) begin
                busy_q <= 1'b0;
                core_t <= 0;
                dout   <= tbl[param][read_source];
            end else begin
                busy_q <= 1'b1;
                core_t <= core_t + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int         rp_cnt = 0, done_cnt = 0, rp_dbl = 0;
    logic       rp_prev = 1'b0;
    logic [4:0] rp_log [$];

    always @(posedge clk) begin
        rp_prev <= read_param;
        if (read_param) begin
            rp_cnt <= rp_cnt + 1;
            rp_log.push_back({param, read_source});
            if (rp_prev) rp_dbl <= rp_dbl + 1;
        end
        if (rd_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- reference snapshot ----------------
    logic [4:0]  e_trig = '0;
    logic [23:0] e_boot = '0;
    logic        e_anf  = 1'b0;
    logic        e_wden = 1'b0;
    logic [11:0] e_wdto = '0;

    task automatic apply(input int i);
        logic [4:0]  e;
        logic [23:0] v;
        e = lst[i];
        v = tbl[e[4:2]][e[1:0]];
        case (i)
            0: e_trig = v[4:0];
            1: e_boot = v;
            2: e_anf  = v[0];
            3: e_wden = v[0];
            default: e_wdto = v[11:0];
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_snap(input string tag);
        chk({tag, "_trig"}, 32'(trig_cond), 32'(e_trig));
        chk({tag, "_boot"}, 32'(boot_addr), 32'(e_boot));
        chk({tag, "_anf"},  32'(anf),       32'(e_anf));
        chk({tag, "_wden"}, 32'(wd_en),     32'(e_wden));
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
        chk({tag, "_wdto"}, 32'(wd_timeout), 32'(e_wdto));
`endif
    endtask

    task automatic rand_tbl();
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < 4; s++)
                tbl[p][s] = 24'($urandom);
    endtask

    // One readback sequence. dead_from: index of first entry the core ignores
    // (>= N: none). hold: cycles busy is held high at start. restart: extra
    // rd_start pulses mid-sequence.
    task automatic seq(input string tag, input int dead_from, input int hold, input bit restart);
        int rp0, d0, c_rp, c_err, nrp;
        bit fin, ord_ok;
        rp0 = rp_cnt; d0 = done_cnt; fin = 0; c_rp = -1; c_err = -1;
        core_dead  = (dead_from == 0);
        force_busy = (hold > 0);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        chk({tag, "_err_clr"}, 32'(rd_error), 32'd0);
        chk({tag, "_active"}, 32'(rd_active), 32'd1);
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            chk({tag, "_hold_norp"}, 32'(rp_cnt - rp0), 32'd0);
            chk({tag, "_hold_param"}, 32'(param), 32'(lst[0][4:2]));
            force_busy = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rd_start = restart && (c == 3 || c == 10 || c == 17);
            core_dead = ((rp_cnt - rp0) >= dead_from);
            if (c_rp < 0 && dead_from < N && (rp_cnt - rp0) == dead_from + 1) c_rp = c;
            if (done_cnt != d0 || rd_error) begin
                fin = 1; c_err = c;
                break;
            end
        end
        rd_start  = 1'b0;
        core_dead = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        repeat (3) @(negedge clk);
        nrp = (dead_from < N) ? dead_from + 1 : N;
        chk({tag, "_rp_cnt"}, 32'(rp_cnt - rp0), 32'(nrp));
        ord_ok = 1;
        for (int i = 0; i < nrp && rp0 + i < rp_log.size(); i++)
            if (rp_log[rp0 + i] !== lst[i]) ord_ok = 0;
        chk({tag, "_rp_order"}, 32'(ord_ok), 32'd1);
        chk({tag, "_rp_single"}, 32'(rp_dbl), 32'd0);
        chk({tag, "_idle"}, 32'(rd_active), 32'd0);
        for (int i = 0; i < N && i < dead_from; i++) apply(i);
        if (dead_from >= N) begin
            chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
            chk({tag, "_err"}, 32'(rd_error), 32'd0);
        end else begin
            chk({tag, "_done"}, 32'(done_cnt - d0), 32'd0);
            chk({tag, "_err"}, 32'(rd_error), 32'd1);
            chk({tag, "_to_len"}, 32'(c_err - c_rp), 32'(TO));
        end
        chk_snap(tag);
    endtask

    initial begin
        int rp0;
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_active", 32'(rd_active), 32'd0);
        chk("rst_done", 32'(rd_done), 32'd0);
        chk("rst_err", 32'(rd_error), 32'd0);
        chk("rst_rp", 32'(read_param), 32'd0);
        chk("rst_param", 32'({param, read_source}), 32'd0);
        chk_snap("rst");
        rst = 1'b0;
        @(negedge clk);

        // Directed values
        rand_tbl();
        tbl[0][1] = 24'hABCDE4;
        tbl[4][0] = 24'h040000;
        tbl[5][0] = 24'h000001;
        tbl[3][0] = 24'hFFFFFE;
        tbl[2][0] = 24'h000ABC;
        seq("t1", N, 0, 0);
        chk("t1_trig_k", 32'(trig_cond), 32'h04);
        chk("t1_boot_k", 32'(boot_addr), 32'h040000);
        chk("t1_anf_k", 32'(anf), 32'd1);
        chk("t1_wden_k", 32'(wd_en), 32'd0);
`ifdef REMOTE_UPDATE_RD_WDTIMEOUT_EN
        chk("t6_wdto_k", 32'(wd_timeout), 32'hABC);
`endif

        // Random tables
        for (int k = 0; k < 4; k++) begin
            rand_tbl();
            seq("rnd", N, 0, 0);
        end

        // Busy held at start
        rand_tbl();
        seq("t2", N, 10, 0);

        // Timeouts at first and third entry, then recovery
        rand_tbl();
        seq("t3a", 0, 0, 0);
        rand_tbl();
        seq("t3b", 2, 0, 0);
        rand_tbl();
        seq("t3c", N, 0, 0);

        // Reset during WAIT_LO of entry 2, with rd_start in the same cycle
        rand_tbl();
        rp0 = rp_cnt;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if ((rp_cnt - rp0) == 3 && busy) begin seen = 1; break; end
        end
        chk("t4_reach", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        e_trig = '0; e_boot = '0; e_anf = 1'b0; e_wden = 1'b0; e_wdto = '0;
        chk("t4_active", 32'(rd_active), 32'd0);
        chk("t4_rp", 32'(read_param), 32'd0);
        chk("t4_param", 32'(param), 32'd0);
        chk_snap("t4");
        rst = 1'b0;
        rd_start = 1'b0;
        @(negedge clk);
        chk("t4_stay_idle", 32'(rd_active), 32'd0);

        // Repeated rd_start mid-sequence
        rand_tbl();
        seq("t5", N, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
